// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD : access-size encodings (2'b11 behaves as word)
//   lsu_state_t             : controller state encoding
//   DM_WORD_BYTES           : bytes per data-memory word
//   is_sub_word()           : 1 for byte/halfword accesses
package lsu_pkg;

    localparam int DM_WORD_BYTES = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    function automatic logic is_sub_word(input logic [1:0] sz);
        return (sz == SZ_BYTE) || (sz == SZ_HALF);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: word-only data-memory (DM) bus.
//   Mem_addr   : word-aligned address        (master -> slave)
//   Mem_w_data : write data                  (master -> slave)
//   Mem_w      : write enable, DM commits on the falling clock edge
//   Mem_r      : read enable
//   Mem_r_data : read data, combinational from Mem_addr (slave -> master)
// There is no ready/valid handshake: the DM is single-cycle, so a read
// returns data in the same cycle Mem_r is high and a write completes in
// the cycle Mem_w is high.
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] Mem_addr;
    logic [31:0]       Mem_w_data;
    logic              Mem_w;
    logic              Mem_r;
    logic [31:0]       Mem_r_data;

    modport master (
        output Mem_addr,
        output Mem_w_data,
        output Mem_w,
        output Mem_r,
        input  Mem_r_data
    );

    modport slave (
        input  Mem_addr,
        input  Mem_w_data,
        input  Mem_w,
        input  Mem_r,
        output Mem_r_data
    );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: combinational big-endian lane logic (byte offset 0 = [31:24]).
//   size, offset : access size and byte offset within the word
//   sign_ext     : load extension mode
//   rd_word      : word being read, source for load extraction
//   base_word    : previously read word, base for store merge
//   wdata        : right-aligned store data
//   load_val     : extracted and extended load result
//   merge_val    : word to write back
// Halfwords use offset[1] only; words ignore the offset.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] rd_word,
    input  logic [31:0] base_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merge_val
);

    function automatic logic [31:0] lane_extract(
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        sext,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (sz)
            SZ_BYTE: begin
                case (off)
                    2'd0:    b = word[31:24];
                    2'd1:    b = word[23:16];
                    2'd2:    b = word[15:8];
                    default: b = word[7:0];
                endcase
                return {{24{sext & b[7]}}, b};
            end
            SZ_HALF: begin
                h = off[1] ? word[15:0] : word[31:16];
                return {{16{sext & h[15]}}, h};
            end
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic [31:0] base,
        input logic [31:0] data
    );
        logic [31:0] m;
        m = base;
        case (sz)
            SZ_BYTE: begin
                case (off)
                    2'd0:    m[31:24] = data[7:0];
                    2'd1:    m[23:16] = data[7:0];
                    2'd2:    m[15:8]  = data[7:0];
                    default: m[7:0]   = data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) m[15:0]  = data[15:0];
                else        m[31:16] = data[15:0];
            end
            default: m = data;
        endcase
        return m;
    endfunction

    assign load_val  = lane_extract(size, offset, sign_ext, rd_word);
    assign merge_val = lane_merge(size, offset, base_word, wdata);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store initiator for a word-only DM.
//   clk, rst   : clock, synchronous active-high reset
//   req        : request strobe, sampled only in IDLE
//   we         : 1 store, 0 load
//   size       : 00 byte, 01 half, 10/11 word
//   sign_ext   : load extension mode
//   addr       : byte address
//   wdata      : right-aligned store data
//   rdata      : last load result, held until the next load completes
//   busy       : high in every state except IDLE
//   done       : one-cycle completion pulse
//   err        : misalignment flag (only with LSU_ALIGN_CHECK_EN)
//   dbg_state  : current controller state
//   mem        : DM bus master
// Sub-word stores are read-modify-write (RD then WR). Optional macro
// LSU_ALIGN_CHECK_EN: misaligned half/word accesses complete immediately
// with err=1 and touch neither rdata nor memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
`ifdef LSU_ALIGN_CHECK_EN
    output logic              err,
`endif
    output lsu_state_t        dbg_state,
    lsu_if.master             mem
);

    lsu_state_t        state, state_nx;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;
    logic              misaligned;

    logic [ADDR_W-1:0] mem_addr_c;
    logic [31:0]       mem_w_data_c;
    logic              mem_w_c;
    logic              mem_r_c;

`ifdef LSU_ALIGN_CHECK_EN
    logic err_q;
    assign misaligned = ((size == SZ_HALF) && addr[0]) ||
                        (!is_sub_word(size) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    lsu_lane u_lane (
        .size      (size_q),
        .offset    (addr_q[1:0]),
        .sign_ext  (sext_q),
        .rd_word   (mem.Mem_r_data),
        .base_word (word_q),
        .wdata     (wdata_q),
        .load_val  (load_val),
        .merge_val (merge_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req) begin
                we_q    <= we;
                size_q  <= size;
                sext_q  <= sign_ext;
                addr_q  <= addr;
                wdata_q <= wdata;
`ifdef LSU_ALIGN_CHECK_EN
                err_q   <= misaligned;
`endif
            end
            if (state == ST_RD) begin
                word_q <= mem.Mem_r_data;
                // Extract straight from the bus: word_q only holds it after this edge.
                if (!we_q) rdata_q <= load_val;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        mem_addr_c   = '0;
        mem_w_data_c = '0;
        mem_w_c      = 1'b0;
        mem_r_c      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (misaligned)                      state_nx = ST_DONE;
                    else if (we && !is_sub_word(size))   state_nx = ST_WR;
                    else                                 state_nx = ST_RD;
                end
            end
            ST_RD: begin
                mem_r_c    = 1'b1;
                mem_addr_c = {addr_q[ADDR_W-1:2], 2'b00};
                state_nx   = we_q ? ST_WR : ST_DONE;
            end
            ST_WR: begin
                // Gated by rst so a reset during WR cannot corrupt DM.
                mem_w_c      = !rst;
                mem_addr_c   = {addr_q[ADDR_W-1:2], 2'b00};
                mem_w_data_c = merge_val;
                state_nx     = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign mem.Mem_addr   = mem_addr_c;
    assign mem.Mem_w_data = mem_w_data_c;
    assign mem.Mem_w      = mem_w_c;
    assign mem.Mem_r      = mem_r_c;

    assign rdata     = rdata_q;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;
`ifdef LSU_ALIGN_CHECK_EN
    assign err       = err_q && (state == ST_DONE);
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit.
// A 256-byte big-endian DM model serves the DUT; a separate byte-array
// reference applies each request with plain byte arithmetic and predicts
// load results, write data, latency and bus activity.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err_obs;
    lsu_state_t  dbg_state;

    lsu_if #(.ADDR_W(32)) mem_bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
`ifdef LSU_ALIGN_CHECK_EN
        .err       (err_obs),
`endif
        .dbg_state (dbg_state),
        .mem       (mem_bus.master)
    );

`ifndef LSU_ALIGN_CHECK_EN
    assign err_obs = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    // DM model
    logic [7:0] dm [0:255];
    logic [7:0] init_img [0:255];
    logic [7:0] ref_mem [0:255];
    logic       preload = 1'b0;

    assign mem_bus.Mem_r_data = {dm[mem_bus.Mem_addr[7:0]],
                                 dm[mem_bus.Mem_addr[7:0] | 8'd1],
                                 dm[mem_bus.Mem_addr[7:0] | 8'd2],
                                 dm[mem_bus.Mem_addr[7:0] | 8'd3]};

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) dm[i] <= init_img[i];
        end else if (mem_bus.Mem_w) begin
            dm[mem_bus.Mem_addr[7:0]]        <= mem_bus.Mem_w_data[31:24];
            dm[mem_bus.Mem_addr[7:0] | 8'd1] <= mem_bus.Mem_w_data[23:16];
            dm[mem_bus.Mem_addr[7:0] | 8'd2] <= mem_bus.Mem_w_data[15:8];
            dm[mem_bus.Mem_addr[7:0] | 8'd3] <= mem_bus.Mem_w_data[7:0];
        end
    end

    // scoreboard
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] held_rdata = '0;
    logic [31:0] last_wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model
    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        return {ref_mem[b], ref_mem[b + 8'd1], ref_mem[b + 8'd2], ref_mem[b + 8'd3]};
    endfunction

    function automatic logic [31:0] dm_word(input logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        return {dm[b], dm[b + 8'd1], dm[b + 8'd2], dm[b + 8'd3]};
    endfunction

    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef LSU_ALIGN_CHECK_EN
        if (sz == 2'd1) return a[0];
        if (sz >= 2'd2) return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // half-word base drops addr[0]; word base drops addr[1:0]
    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [7:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        if (sz == 2'd0) begin
            b = ref_mem[a];
            return sx ? 32'($signed(b)) : {24'h0, b};
        end else if (sz == 2'd1) begin
            h = {ref_mem[a & 8'hFE], ref_mem[(a & 8'hFE) + 8'd1]};
            return sx ? 32'($signed(h)) : {16'h0, h};
        end
        return ref_word(a);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
        logic [7:0] b;
        if (sz == 2'd0) begin
            ref_mem[a] = d[7:0];
        end else if (sz == 2'd1) begin
            b = a & 8'hFE;
            ref_mem[b]        = d[15:8];
            ref_mem[b + 8'd1] = d[7:0];
        end else begin
            b = a & 8'hFC;
            ref_mem[b]        = d[31:24];
            ref_mem[b + 8'd1] = d[23:16];
            ref_mem[b + 8'd2] = d[15:8];
            ref_mem[b + 8'd3] = d[7:0];
        end
    endtask

    // driver: one request, watched until done (bounded)
    task automatic run_op(input logic op_we, input logic [1:0] op_size, input logic op_sext,
                          input logic [31:0] op_addr, input logic [31:0] op_wdata,
                          input bit pulse_busy);
        bit          mis;
        int          exp_lat, exp_rd, exp_wr;
        int          lat, rd_n, wr_n, bad_bus, idle_n, extra_done;
        logic        got, got_err;
        logic [31:0] al;

        mis     = ref_misaligned(op_size, op_addr);
        al      = {op_addr[31:2], 2'b00};
        exp_lat = mis ? 1 : ((!op_we || op_size >= 2'd2) ? 2 : 3);
        exp_rd  = (mis || (op_we && op_size >= 2'd2)) ? 0 : 1;
        exp_wr  = (!mis && op_we) ? 1 : 0;

        if (!mis) begin
            if (op_we) ref_store(op_size, op_addr[7:0], op_wdata);
            else       held_rdata = ref_load(op_size, op_sext, op_addr[7:0]);
        end
        exp_q.push_back(held_rdata);

        @(negedge clk);
        req = 1'b1; we = op_we; size = op_size; sign_ext = op_sext;
        addr = op_addr; wdata = op_wdata;
        @(posedge clk);

        got = 1'b0; got_err = 1'b0; lat = 0; rd_n = 0; wr_n = 0;
        bad_bus = 0; idle_n = 0; last_wr_data = '0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (c == 1 && pulse_busy) begin
                req = 1'b1; we = ~op_we; addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
            end
            if (!busy) idle_n++;
            if (mem_bus.Mem_r) rd_n++;
            if (mem_bus.Mem_w) begin
                wr_n++;
                last_wr_data = mem_bus.Mem_w_data;
            end
            if ((mem_bus.Mem_r || mem_bus.Mem_w) && mem_bus.Mem_addr !== al) bad_bus++;
            if (!mem_bus.Mem_r && !mem_bus.Mem_w &&
                (mem_bus.Mem_addr !== '0 || mem_bus.Mem_w_data !== '0)) bad_bus++;
            if (done) begin
                got = 1'b1; lat = c; got_err = err_obs;
            end
        end
        req = 1'b0;

        check("latency", lat, exp_lat);
        check("rd_cycles", rd_n, exp_rd);
        check("wr_cycles", wr_n, exp_wr);
        check("bus_idle_values", bad_bus, 0);
        check("busy_high", idle_n, 0);
        check("err", {31'b0, got_err}, {31'b0, mis});
        check("rdata", rdata, exp_q.pop_front());
        if (op_we && !mis) check("wr_data", last_wr_data, ref_word(op_addr[7:0]));
        check("dm_word", dm_word(op_addr[7:0]), ref_word(op_addr[7:0]));

        if (pulse_busy) begin
            extra_done = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (done) extra_done++;
            end
            check("ignored_req_done", extra_done, 0);
        end
    endtask

    initial begin
        int bad_bytes;
        int extra;

        for (int i = 0; i < 256; i++) begin
            init_img[i] = 8'($urandom);
            ref_mem[i]  = init_img[i];
        end
        for (int i = 32; i < 36; i++) begin
            init_img[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end

        // reset
        preload = 1'b1;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_mem_r", {31'b0, mem_bus.Mem_r}, 32'h0);
        check("rst_mem_w", {31'b0, mem_bus.Mem_w}, 32'h0);
        check("rst_mem_addr", mem_bus.Mem_addr, 32'h0);
        check("rst_mem_w_data", mem_bus.Mem_w_data, 32'h0);
        check("rst_err", {31'b0, err_obs}, 32'h0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        rst = 1'b0;

        // word store then load at 0x10
        run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        check("dm_10_bytes", {dm[16], dm[17], dm[18], dm[19]}, 32'hDEADBEEF);
        run_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
        check("ld_word_10", rdata, 32'hDEADBEEF);

        // byte store over 0x11223344
        run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0);
        run_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000005A, 1'b0);
        check("sb_merge", last_wr_data, 32'h115A3344);

        // halfword loads at 0x12
        run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234F00D, 1'b0);
        run_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
        check("lh_sext", rdata, 32'hFFFFF00D);
        run_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0);
        check("lh_zext", rdata, 32'h0000F00D);

        // byte load with a request pulsed while busy
        run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h000000FF, 1'b0);
        run_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1);
        check("lb_sext", rdata, 32'hFFFFFFFF);

        // reset during WR of a word store
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0;
        addr = 32'h20; wdata = 32'hCAFEBABE;
        @(posedge clk);
        #1 rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("rstwr_state", {30'b0, dbg_state}, {30'b0, ST_WR});
        check("rstwr_mem_w", {31'b0, mem_bus.Mem_w}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        held_rdata = '0;
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) extra++;
            if (c == 0) check("rstwr_idle", {30'b0, dbg_state}, {30'b0, ST_IDLE});
        end
        check("rstwr_no_done", extra, 0);
        check("rstwr_dm", dm_word(8'h20), 32'h0);
        check("rstwr_rdata", rdata, 32'h0);

        // word load at 0x22: misaligned with the check, reads 0x20 without
        run_op(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)),
                   {$urandom_range(0, 15), 20'h0, 8'($urandom_range(0, 255))},
                   $urandom, 1'($urandom_range(0, 7) == 0));
        end

        bad_bytes = 0;
        for (int i = 0; i < 256; i++) if (dm[i] !== ref_mem[i]) bad_bytes++;
        check("dm_final", bad_bytes, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator between the CPU datapath and the word-only data memory `DM`. It accepts byte, halfword and word load/store requests and turns them into `DM` read/write cycles, using read-modify-write for sub-word stores. Byte order is big-endian: byte offset 0 is bits [31:24]. The block sits in the MEM stage and stalls the pipeline through `busy`.

## Interface
Parameters:
- `ADDR_W`, 32: address width on both sides.

Ports:
- `clk`  in  1  single clock; the block itself is posedge-only.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata`  out  32  load result, extended to 32 bits; held until the next load completes.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  misalignment flag; present only with `LSU_ALIGN_CHECK_EN`.
- `Mem_addr`  out  32  word-aligned `DM` address.
- `Mem_w_data`  out  32  `DM` write data.
- `Mem_w`  out  1  `DM` write enable.
- `Mem_r`  out  1  `DM` read enable.
- `Mem_r_data`  in  32  `DM` read data; combinational from `Mem_addr`.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE with `req`=1:
  - Latch `we`, `size`, `sign_ext`, `addr`, `wdata`.
  - Go to WR for a word store; otherwise go to RD.
- Requests that arrive while `busy`=1 are ignored; they are not queued.
- RD:
  - `Mem_r`=1 and `Mem_addr`={addr_q[31:2],2'b00}.
  - Capture `Mem_r_data` into `word_q` at the posedge.
  - A load then goes to DONE; a sub-word store goes to WR.
- Load extraction (from the captured word):
  - Byte: offset k selects bits [31-8k : 24-8k].
  - Halfword: offset 0 selects [31:16]; offset 2 selects [15:0].
  - `rdata` is updated on the RD→DONE edge.
- WR:
  - `Mem_w`=1 with the same aligned `Mem_addr`.
  - `Mem_w_data` is `wdata_q` for a word store.
  - For a sub-word store it is `word_q` with the addressed lane replaced by `wdata_q[7:0]` or `wdata_q[15:0]`.
  - WR always goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Outside RD, `Mem_r`=0. Outside WR, `Mem_w`=0 and `Mem_w_data`=0. In IDLE and DONE, `Mem_addr`=0.
- Reset values: state IDLE; `rdata`=0; `busy`, `done`, `err`, `Mem_r`, `Mem_w`=0; `Mem_addr`=0; `Mem_w_data`=0.
- Reset mid-operation:
  - `Mem_w` is gated combinationally by `!rst`. A WR cycle that coincides with `rst`=1 produces no `DM` write (`DM` commits on negedge).
  - The state returns to IDLE and no `done` is issued.

## Timing
- Request accepted at posedge T0.
- Load: RD in cycle T0→T1, `done` in T1→T2. Latency 2.
- Word store: WR in T0→T1, `done` in T1→T2. Latency 2.
- Sub-word store: RD, then WR, then DONE. Latency 3.
- Store data is in `DM` by the negedge inside the WR cycle. A load accepted on the cycle after `done` sees the new data.
- Back-to-back throughput: a new `req` is accepted only in the IDLE cycle after DONE.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, skips RD/WR and goes directly IDLE→DONE.
  - `err`=1 together with `done`; `rdata` and memory are unchanged.
- Not defined:
  - The `err` port is absent.
  - Offending low address bits are ignored: a halfword uses addr[1]; a word uses offset 0.

## Structure
- Package `lsu_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State enum.
  - `DM_WORD_BYTES`=4.
- Sub-module `lsu_lane` (combinational), with two functions:
  - Lane extract plus sign/zero extension, for loads.
  - Lane merge, for stores.
- All FSM and registers live in `load_store_unit`.

## Test plan
- Word store at addr 0x10 of 0xDEADBEEF, then word load at 0x10 → `DM`[0x10..0x13]=DE,AD,BE,EF; `rdata`=0xDEADBEEF; each `done` 2 cycles after accept.
- Byte store 0x5A at 0x11 over 0x11223344 → one RD, then WR with `Mem_w_data`=0x115A3344; `done` 3 cycles after accept.
- Halfword load at 0x12 from 0x1234F00D: `sign_ext`=1 → 0xFFFFF00D; `sign_ext`=0 → 0x0000F00D.
- Byte load at 0x13 from 0x000000FF with `sign_ext`=1 → 0xFFFFFFFF; `req` pulsed while `busy` → ignored, exactly one `done`.
- `rst` asserted during the WR cycle of a word store of 0xCAFEBABE to 0x20 holding 0 → `DM`[0x20] word stays 0; state IDLE; no `done`.
- With `LSU_ALIGN_CHECK_EN`, word load at 0x22 → `Mem_r` never high; `done`=1 and `err`=1 one cycle after accept; without the macro, the same load reads 0x20.
